// File: rtl/conv2_window_buf_pkg.sv
// Shared constants and window_out packing helper for the layer-2 window buffer
// and the conv2 MAC array that consumes its output.
package conv2_window_buf_pkg;

  localparam int DATA_BIT       = 12;
  localparam int HALF_WIDTH     = 12;
  localparam int HALF_HEIGHT    = 12;
  localparam int HALF_WIDTH_BIT = 4;
  localparam int KERNEL         = 3;
  localparam int NUM_CH         = 3;

  localparam int WIN_ELEMS = KERNEL * KERNEL;
  localparam int CH_BITS   = WIN_ELEMS * DATA_BIT;
  localparam int WIN_BITS  = NUM_CH * CH_BITS;

  typedef logic [DATA_BIT-1:0]       pix_t;
  typedef logic [HALF_WIDTH_BIT-1:0] cnt_t;

  // Bit offset of element (channel c, row r with 0 = oldest line, col k with 0 = leftmost).
  function automatic int win_idx(input int c, input int r, input int k);
    return (c * WIN_ELEMS + r * KERNEL + k) * DATA_BIT;
  endfunction

endpackage

// File: rtl/conv2_line_window.sv
// One channel: two line buffers indexed by column plus a 3x3 shifting window.
// win_o element (r,k) sits at bits [(r*KERNEL+k)*DATA_BIT +: DATA_BIT].
module conv2_line_window
  import conv2_window_buf_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               accept_i,
  input  cnt_t               col_i,
  input  pix_t               pix_i,
  output logic [CH_BITS-1:0] win_o
);

  pix_t line_a_q [HALF_WIDTH];
  pix_t line_b_q [HALF_WIDTH];
  pix_t win_q    [KERNEL][KERNEL];
  pix_t rd_a;
  pix_t rd_b;

  assign rd_a = line_a_q[col_i];
  assign rd_b = line_b_q[col_i];

  // Line storage is plain memory; never reset.
  always_ff @(posedge clk) begin
    if (accept_i) begin
      line_b_q[col_i] <= rd_a;
      line_a_q[col_i] <= pix_i;
    end
  end

  // Window cleared on reset so the packed output reads zero right after it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int k = 0; k < KERNEL; k++) begin
          win_q[r][k] <= '0;
        end
      end
    end else if (accept_i) begin
      for (int r = 0; r < KERNEL; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= rd_b;
      win_q[1][2] <= rd_a;
      win_q[2][2] <= pix_i;
    end
  end

  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    for (genvar k = 0; k < KERNEL; k++) begin : g_col
      assign win_o[(r*KERNEL+k)*DATA_BIT +: DATA_BIT] = win_q[r][k];
    end
  end

endmodule

// File: rtl/conv2_window_buf.sv
// Raster-order 3-channel sliding-window generator feeding the conv2 MAC array.
// Owns the column/row counters, valid_out and frame_done; one line-window per channel.
module conv2_window_buf
  import conv2_window_buf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [DATA_BIT-1:0] pix_in_1,
  input  logic [DATA_BIT-1:0] pix_in_2,
  input  logic [DATA_BIT-1:0] pix_in_3,
  output logic [WIN_BITS-1:0] window_out,
  output logic                valid_out,
  output logic                frame_done
);

  localparam cnt_t COL_LAST   = cnt_t'(HALF_WIDTH - 1);
  localparam cnt_t ROW_LAST   = cnt_t'(HALF_HEIGHT - 1);
  localparam cnt_t FIRST_FULL = cnt_t'(KERNEL - 1);

  cnt_t col_q, col_d;
  cnt_t row_q, row_d;
  logic valid_q, valid_d;
  logic done_q, done_d;

  pix_t               pix_ch [NUM_CH];
  logic [CH_BITS-1:0] win_ch [NUM_CH];

  assign pix_ch[0] = pix_in_1;
  assign pix_ch[1] = pix_in_2;
  assign pix_ch[2] = pix_in_3;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (valid_in) begin
      // Columns 0/1 of each line still hold the previous line's tail; col>=2 hides them.
      valid_d = (row_q >= FIRST_FULL) && (col_q >= FIRST_FULL);
      done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + cnt_t'(1);
      end else begin
        col_d = col_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign valid_out  = valid_q;
  assign frame_done = done_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    conv2_line_window u_line_window (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept_i (valid_in),
      .col_i    (col_q),
      .pix_i    (pix_ch[c]),
      .win_o    (win_ch[c])
    );
    for (genvar r = 0; r < KERNEL; r++) begin : g_r
      for (genvar k = 0; k < KERNEL; k++) begin : g_k
        assign window_out[win_idx(c, r, k) +: DATA_BIT] =
          win_ch[c][(r*KERNEL+k)*DATA_BIT +: DATA_BIT];
      end
    end
  end

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: ramp frames with and without gaps, line wrap,
// back-to-back frames, mid-frame reset and max-value data.
module tb_conv2_window_buf;

  localparam int DB = 12;
  localparam int W  = 12;
  localparam int H  = 12;
  localparam int WB = 27 * DB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DB-1:0] pix_in_1, pix_in_2, pix_in_3;
  logic [WB-1:0] window_out;
  logic          valid_out;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int                 r;
    int                 c;
    int                 v;
    logic [8:0][DB-1:0] w;
  } vec_t;

  vec_t          tbl [7];
  logic [WB-1:0] ref_q [$];

  conv2_window_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .pix_in_1   (pix_in_1),
    .pix_in_2   (pix_in_2),
    .pix_in_3   (pix_in_3),
    .window_out (window_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r, input int c, input int v,
                              input int a0, input int a1, input int a2,
                              input int a3, input int a4, input int a5,
                              input int a6, input int a7, input int a8);
    vec_t t;
    t.r = r; t.c = c; t.v = v;
    t.w[0] = a0[DB-1:0]; t.w[1] = a1[DB-1:0]; t.w[2] = a2[DB-1:0];
    t.w[3] = a3[DB-1:0]; t.w[4] = a4[DB-1:0]; t.w[5] = a5[DB-1:0];
    t.w[6] = a6[DB-1:0]; t.w[7] = a7[DB-1:0]; t.w[8] = a8[DB-1:0];
    return t;
  endfunction

  // Expected window after accepting pixel (r,c) of a ramp frame: ch1 = base+row*12+col,
  // ch2 = ch1+200, ch3 = 0; or every element 4095 for the max-value frame.
  function automatic logic [WB-1:0] exp_win(input int base, input bit maxv, input int r, input int c);
    logic [WB-1:0] w;
    int val;
    w = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int rr = 0; rr < 3; rr++) begin
        for (int k = 0; k < 3; k++) begin
          if (maxv) val = 4095;
          else if (ch == 2) val = 0;
          else val = base + (r - 2 + rr) * W + (c - 2 + k) + ((ch == 1) ? 200 : 0);
          w[(ch*9 + rr*3 + k)*DB +: DB] = val[DB-1:0];
        end
      end
    end
    return w;
  endfunction

  task automatic step(input bit v, input int a, input int b, input int c);
    @(negedge clk);
    valid_in = v;
    pix_in_1 = a[DB-1:0];
    pix_in_2 = b[DB-1:0];
    pix_in_3 = c[DB-1:0];
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 = continuous, 1 = one idle cycle per pixel for six lines then random 0-5.
  task automatic run_frame(input int base, input bit maxv, input int gap_mode,
                           input bit record, input bit cmp_ref, input bit use_tbl,
                           input int stop_n,
                           output int nvalid, output int ndone, output int first_pix,
                           output logic [WB-1:0] first_win);
    int n, ridx, ng, v1, v2, v3;
    logic [WB-1:0] last;
    n = 0; ridx = 0; nvalid = 0; ndone = 0; first_pix = -1; first_win = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        v1 = maxv ? 4095 : base + r * W + c;
        v2 = maxv ? 4095 : v1 + 200;
        v3 = maxv ? 4095 : 0;
        step(1'b1, v1, v2, v3);
        n++;
        chk("valid_out", 32'(valid_out), 32'((r >= 2 && c >= 2) ? 1 : 0));
        chk("frame_done", 32'(frame_done), 32'((r == H-1 && c == W-1) ? 1 : 0));
        if (frame_done) ndone++;
        if (valid_out) begin
          nvalid++;
          if (first_pix < 0) begin
            first_pix = n;
            first_win = window_out;
          end
          chk_w("window", window_out, exp_win(base, maxv, r, c));
          if (record) ref_q.push_back(window_out);
          if (cmp_ref) begin
            if (ridx < ref_q.size()) chk_w("ref_seq", window_out, ref_q[ridx]);
            ridx++;
          end
        end
        if (use_tbl) begin
          for (int t = 0; t < 7; t++) begin
            if (tbl[t].r == r && tbl[t].c == c) begin
              chk("tbl_valid", 32'(valid_out), 32'(tbl[t].v));
              if (tbl[t].v != 0) begin
                for (int j = 0; j < 9; j++) chk("tbl_ch1", 32'(window_out[j*DB +: DB]), 32'(tbl[t].w[j]));
              end
            end
          end
        end
        if (n == stop_n) return;
        last = window_out;
        if (gap_mode == 0) ng = 0;
        else if (r < 6) ng = 1;
        else ng = int'($urandom_range(0, 5));
        for (int g = 0; g < ng; g++) begin
          step(1'b0, int'($urandom), int'($urandom), int'($urandom));
          chk("gap_valid", 32'(valid_out), 32'd0);
          chk("gap_done", 32'(frame_done), 32'd0);
          chk_w("gap_hold", window_out, last);
        end
      end
    end
    if (cmp_ref) chk("ref_len", 32'(ridx), 32'(ref_q.size()));
  endtask

  initial begin
    int nv, nd, fp, nv2, nd2, fp2;
    logic [WB-1:0] fw, fw2;
    int f2 [9];

    // Ramp value is row*12+col, so the last window spans rows 9-11, cols 9-11.
    tbl[0] = mk(2, 2, 1, 0, 1, 2, 12, 13, 14, 24, 25, 26);
    tbl[1] = mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(3, 2, 1, 12, 13, 14, 24, 25, 26, 36, 37, 38);
    tbl[5] = mk(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6] = mk(11, 11, 1, 117, 118, 119, 129, 130, 131, 141, 142, 143);
    f2 = '{1000, 1001, 1002, 1012, 1013, 1014, 1024, 1025, 1026};

    rst_n = 1'b0; valid_in = 1'b0; pix_in_1 = '0; pix_in_2 = '0; pix_in_3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk_w("rst_window", window_out, '0);
    rst_n = 1'b1;

    // Continuous ramp frame; records the reference window sequence.
    run_frame(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, -1, nv, nd, fp, fw);
    chk("t1_nvalid", 32'(nv), 32'd100);
    chk("t1_ndone", 32'(nd), 32'd1);
    chk("t1_first_pix", 32'(fp), 32'd27);

    // Same frame with gaps.
    run_frame(0, 1'b0, 1, 1'b0, 1'b1, 1'b0, -1, nv, nd, fp, fw);
    chk("t2_nvalid", 32'(nv), 32'd100);
    chk("t2_ndone", 32'(nd), 32'd1);

    // Back-to-back frames, second offset by 1000.
    run_frame(0, 1'b0, 0, 1'b0, 1'b1, 1'b0, -1, nv, nd, fp, fw);
    run_frame(1000, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1, nv2, nd2, fp2, fw2);
    chk("t4_nvalid", 32'(nv + nv2), 32'd200);
    chk("t4_ndone", 32'(nd + nd2), 32'd2);
    chk("t4_first_pix2", 32'(fp2), 32'd27);
    for (int j = 0; j < 9; j++) chk("t4_first_win2", 32'(fw2[j*DB +: DB]), 32'(f2[j]));

    // Reset right after pixel (5,7), then a fresh ramp.
    run_frame(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5*W + 7 + 1, nv, nd, fp, fw);
    chk("t5_pre_valid", 32'(valid_out), 32'd1);
    @(negedge clk);
    rst_n = 1'b0; valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rst_valid", 32'(valid_out), 32'd0);
    chk("t5_rst_done", 32'(frame_done), 32'd0);
    chk_w("t5_rst_window", window_out, '0);
    rst_n = 1'b1;
    run_frame(0, 1'b0, 0, 1'b0, 1'b1, 1'b0, -1, nv, nd, fp, fw);
    chk("t5_nvalid", 32'(nv), 32'd100);
    chk("t5_ndone", 32'(nd), 32'd1);

    // Full-scale data on every channel.
    run_frame(0, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1, nv, nd, fp, fw);
    chk("t6_nvalid", 32'(nv), 32'd100);
    chk_w("t6_first_win", fw, {WB{1'b1}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d errors of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
